// File: rtl/mr_bus_pkg.sv
// Shared types and helpers for the memory-bus arbiter and its in-flight counter.
package mr_bus_pkg;

  localparam int XLEN      = 32;
  localparam int XLEN_GRAN = 2;
  localparam int ADR_W     = XLEN - XLEN_GRAN;
  localparam int SEL_W     = XLEN / 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

  // One Wishbone request as seen by the slave port.
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [XLEN-1:0]  dat;
    logic             we;
    logic [SEL_W-1:0] sel;
  } wb_req_t;

  // Counter width able to hold 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/mr_bus_inflight.sv
// Saturating up/down counter of accepted-but-uncompleted bus requests.
module mr_bus_inflight
  import mr_bus_pkg::*;
#(
  parameter int MAX_OUT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic full_o,
  output logic empty_o
);

  localparam int CNT_W = cnt_w(MAX_OUT);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins; simultaneous inc and dec hold; both ends saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign full_o  = (cnt_q == MAX_CNT);
  assign empty_o = (cnt_q == '0);

  a_cnt_le_max: assert property (@(posedge clk) disable iff (rst) cnt_q <= MAX_CNT);

endmodule

// File: rtl/mr_bus_arb.sv
// Two-master (fetch M_I, load/store M_D) to one-slave pipelined Wishbone arbiter.
module mr_bus_arb
  import mr_bus_pkg::*;
#(
  parameter int MAX_OUT = 2,
  parameter int RR_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] i_adr_i,
  input  logic             i_cyc_i,
  input  logic             i_stb_i,
  output logic             i_stall_o,
  output logic             i_ack_o,
  output logic             i_err_o,
  output logic [XLEN-1:0]  i_dat_o,
  input  logic [ADR_W-1:0] d_adr_i,
  input  logic [XLEN-1:0]  d_dat_i,
  input  logic             d_we_i,
  input  logic [SEL_W-1:0] d_sel_i,
  input  logic             d_cyc_i,
  input  logic             d_stb_i,
  output logic             d_stall_o,
  output logic             d_ack_o,
  output logic             d_err_o,
  output logic [XLEN-1:0]  d_dat_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [XLEN-1:0]  s_dat_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic             s_stall_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic [XLEN-1:0]  s_dat_i,
  output gnt_e             gnt_o
);

  gnt_e    state_q, state_d;
  logic    last_d_q, last_d_d;
  logic    cnt_inc, cnt_dec, cnt_clr, cnt_full, cnt_empty;
  logic    d_wins;
  wb_req_t i_req, d_req, s_req;

  // Fetch never writes and always reads the full word.
  always_comb begin
    i_req.adr = i_adr_i;
    i_req.dat = '0;
    i_req.we  = 1'b0;
    i_req.sel = '1;
    d_req.adr = d_adr_i;
    d_req.dat = d_dat_i;
    d_req.we  = d_we_i;
    d_req.sel = d_sel_i;
  end

  mr_bus_inflight #(.MAX_OUT(MAX_OUT)) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (cnt_inc),
    .dec_i   (cnt_dec),
    .clr_i   (cnt_clr),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  // From idle, M_D takes a tie unless round-robin says it had the bus last.
  assign d_wins = d_cyc_i && (!i_cyc_i || (RR_MODE == 0) || !last_d_q);

  // Grant next-state plus request/response routing for the current owner.
  always_comb begin
    state_d   = state_q;
    s_req     = i_req;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    i_stall_o = 1'b1;
    d_stall_o = 1'b1;
    i_ack_o   = 1'b0;
    i_err_o   = 1'b0;
    d_ack_o   = 1'b0;
    d_err_o   = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      GNT_NONE: begin
        if (d_wins)       state_d = GNT_D;
        else if (i_cyc_i) state_d = GNT_I;
      end
      GNT_I: begin
        s_req     = i_req;
        s_cyc_o   = i_cyc_i;
        s_stb_o   = i_cyc_i && i_stb_i && !cnt_full;
        i_stall_o = s_stall_i || cnt_full;
        i_ack_o   = s_ack_i;
        i_err_o   = s_err_i;
        // Dropping cyc ends the cycle; anything still in flight is abandoned.
        if (!i_cyc_i) begin
          cnt_clr = 1'b1;
          state_d = d_cyc_i ? GNT_D : GNT_NONE;
        end
      end
      GNT_D: begin
        s_req     = d_req;
        s_cyc_o   = d_cyc_i;
        s_stb_o   = d_cyc_i && d_stb_i && !cnt_full;
        d_stall_o = s_stall_i || cnt_full;
        d_ack_o   = s_ack_i;
        d_err_o   = s_err_i;
        if (!d_cyc_i) begin
          cnt_clr = 1'b1;
          state_d = i_cyc_i ? GNT_I : GNT_NONE;
        end
      end
      default: state_d = GNT_NONE;
    endcase
  end

  // Remember which master was granted most recently, for round-robin ties.
  always_comb begin
    last_d_d = last_d_q;
    if (state_d == GNT_D)      last_d_d = 1'b1;
    else if (state_d == GNT_I) last_d_d = 1'b0;
  end

  // Grant state and last-grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GNT_NONE;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  assign cnt_inc = s_stb_o && !s_stall_i;
  assign cnt_dec = s_ack_i || s_err_i;

  assign s_adr_o = s_req.adr;
  assign s_dat_o = s_req.dat;
  assign s_we_o  = s_req.we;
  assign s_sel_o = s_req.sel;
  assign i_dat_o = s_dat_i;
  assign d_dat_o = s_dat_i;
  assign gnt_o   = state_q;

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    ((state_q != GNT_NONE) && cnt_empty) |-> !(s_ack_i || s_err_i));
  a_ack_err_excl: assert property (@(posedge clk) disable iff (rst)
    !(s_ack_i && s_err_i));

endmodule

// File: tb/tb_mr_bus_arb.sv
// Bench for mr_bus_arb: directed scenarios plus a randomized run against a transaction model.
module tb_mr_bus_arb;
  import mr_bus_pkg::*;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [ADR_W-1:0] i_adr, d_adr, s_adr;
  logic             i_cyc, i_stb, d_cyc, d_stb, d_we;
  logic [XLEN-1:0]  d_dat, s_dat, i_dato, d_dato, s_dato;
  logic [SEL_W-1:0] d_sel, s_sel;
  logic             s_stall, s_ack, s_err;
  logic             i_stall, i_ack, i_err, d_stall, d_ack, d_err, s_cyc, s_stb, s_we;
  gnt_e             gnt;

  logic             r_i_cyc, r_d_cyc;
  logic             r_i_stall, r_i_ack, r_i_err, r_d_stall, r_d_ack, r_d_err;
  logic             r_s_cyc, r_s_stb, r_s_we;
  logic [XLEN-1:0]  r_i_dat, r_d_dat, r_s_dat;
  logic [ADR_W-1:0] r_s_adr;
  logic [SEL_W-1:0] r_s_sel;
  gnt_e             r_gnt;

  int checks = 0;
  int errors = 0;

  mr_bus_arb #(.MAX_OUT(MAXO), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst),
    .i_adr_i(i_adr), .i_cyc_i(i_cyc), .i_stb_i(i_stb),
    .i_stall_o(i_stall), .i_ack_o(i_ack), .i_err_o(i_err), .i_dat_o(i_dato),
    .d_adr_i(d_adr), .d_dat_i(d_dat), .d_we_i(d_we), .d_sel_i(d_sel),
    .d_cyc_i(d_cyc), .d_stb_i(d_stb),
    .d_stall_o(d_stall), .d_ack_o(d_ack), .d_err_o(d_err), .d_dat_o(d_dato),
    .s_adr_o(s_adr), .s_dat_o(s_dato), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_stall_i(s_stall), .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat),
    .gnt_o(gnt)
  );

  mr_bus_arb #(.MAX_OUT(MAXO), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .i_adr_i(i_adr), .i_cyc_i(r_i_cyc), .i_stb_i(1'b0),
    .i_stall_o(r_i_stall), .i_ack_o(r_i_ack), .i_err_o(r_i_err), .i_dat_o(r_i_dat),
    .d_adr_i(d_adr), .d_dat_i(d_dat), .d_we_i(d_we), .d_sel_i(d_sel),
    .d_cyc_i(r_d_cyc), .d_stb_i(1'b0),
    .d_stall_o(r_d_stall), .d_ack_o(r_d_ack), .d_err_o(r_d_err), .d_dat_o(r_d_dat),
    .s_adr_o(r_s_adr), .s_dat_o(r_s_dat), .s_we_o(r_s_we), .s_sel_o(r_s_sel),
    .s_cyc_o(r_s_cyc), .s_stb_o(r_s_stb),
    .s_stall_i(1'b0), .s_ack_i(1'b0), .s_err_i(1'b0), .s_dat_i(s_dat),
    .gnt_o(r_gnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic idle_inputs();
    i_adr = '0; i_cyc = 1'b0; i_stb = 1'b0;
    d_adr = '0; d_dat = '0; d_we = 1'b0; d_sel = '0; d_cyc = 1'b0; d_stb = 1'b0;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
    r_i_cyc = 1'b0; r_d_cyc = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    look();
    checks++;
    if ({s_cyc, s_stb, s_we} !== 3'b000) begin
      errors++; $display("FAIL reset_slave_ctl: got %b want 000", {s_cyc, s_stb, s_we});
    end
    checks++;
    if ({i_stall, d_stall} !== 2'b11) begin
      errors++; $display("FAIL reset_stalls: got %b want 11", {i_stall, d_stall});
    end
    checks++;
    if ({i_ack, i_err, d_ack, d_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_resp: got %b want 0000", {i_ack, i_err, d_ack, d_err});
    end
    checks++;
    if (gnt !== GNT_NONE || r_gnt !== GNT_NONE) begin
      errors++; $display("FAIL reset_gnt: got %0d/%0d want 0/0", gnt, r_gnt);
    end
    step();
  endtask

  task automatic test_single_fetch();
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = ADR_W'(32'h100);
    look();
    checks++;
    if (i_stall !== 1'b1 || s_cyc !== 1'b0) begin
      errors++; $display("FAIL fetch_t0: stall %b cyc %b want 1 0", i_stall, s_cyc);
    end
    step();
    look();
    checks++;
    if (gnt !== GNT_I || s_stb !== 1'b1 || i_stall !== 1'b0 || s_adr !== ADR_W'(32'h100)) begin
      errors++; $display("FAIL fetch_t1: gnt %0d stb %b stall %b adr %h want 1 1 0 100",
                         gnt, s_stb, i_stall, s_adr);
    end
    step();
    i_stb = 1'b0; s_ack = 1'b1; s_dat = 32'h0000_0013;
    look();
    checks++;
    if (i_ack !== 1'b1 || i_dato !== 32'h13 || d_ack !== 1'b0 || d_dato !== 32'h13) begin
      errors++; $display("FAIL fetch_t2: iack %b idat %h dack %b ddat %h want 1 13 0 13",
                         i_ack, i_dato, d_ack, d_dato);
    end
    step();
    s_ack = 1'b0; i_cyc = 1'b0;
    look();
    checks++;
    if (i_ack !== 1'b0 || s_cyc !== 1'b0) begin
      errors++; $display("FAIL fetch_t3: ack %b cyc %b want 0 0", i_ack, s_cyc);
    end
    step();
    look();
    checks++;
    if (gnt !== GNT_NONE) begin
      errors++; $display("FAIL fetch_release: gnt %0d want 0", gnt);
    end
    step();
  endtask

  task automatic test_tie_fixed();
    i_cyc = 1'b1; d_cyc = 1'b1; d_stb = 1'b1; d_adr = ADR_W'(32'h200); d_sel = 4'hF;
    step();
    look();
    checks++;
    if (gnt !== GNT_D || i_stall !== 1'b1 || s_stb !== 1'b1 || s_adr !== ADR_W'(32'h200)) begin
      errors++; $display("FAIL tie_grant: gnt %0d istall %b stb %b adr %h want 2 1 1 200",
                         gnt, i_stall, s_stb, s_adr);
    end
    step();
    d_stb = 1'b0;
    step();
    s_ack = 1'b1;
    look();
    checks++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0 || i_stall !== 1'b1) begin
      errors++; $display("FAIL tie_ack: dack %b iack %b istall %b want 1 0 1", d_ack, i_ack, i_stall);
    end
    step();
    s_ack = 1'b0; d_cyc = 1'b0;
    look();
    checks++;
    if (gnt !== GNT_D || i_stall !== 1'b1) begin
      errors++; $display("FAIL tie_hold: gnt %0d istall %b want 2 1", gnt, i_stall);
    end
    step();
    look();
    checks++;
    if (gnt !== GNT_I || i_stall !== 1'b0) begin
      errors++; $display("FAIL tie_handoff: gnt %0d istall %b want 1 0", gnt, i_stall);
    end
    step();
    i_cyc = 1'b0;
    step();
    step();
  endtask

  task automatic test_max_out();
    logic [10:0] stall_pat;
    stall_pat = 11'b11100111100;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_adr = ADR_W'(32'h300);
    step();
    for (int c = 0; c < 14; c++) begin
      s_ack = (c == 5) || (c == 6) || (c == 11) || (c == 12);
      d_stb = (c <= 7);
      d_cyc = (c < 13);
      look();
      if (c <= 10) begin
        checks++;
        if (d_stall !== stall_pat[c]) begin
          errors++; $display("FAIL maxout_stall c%0d: got %b want %b", c, d_stall, stall_pat[c]);
        end
      end
      if (c <= 7) begin
        checks++;
        if (s_stb !== !stall_pat[c]) begin
          errors++; $display("FAIL maxout_stb c%0d: got %b want %b", c, s_stb, !stall_pat[c]);
        end
      end
      checks++;
      if (d_ack !== s_ack) begin
        errors++; $display("FAIL maxout_ack c%0d: got %b want %b", c, d_ack, s_ack);
      end
      step();
    end
    s_ack = 1'b0;
    look();
    checks++;
    if (gnt !== GNT_NONE) begin
      errors++; $display("FAIL maxout_release: gnt %0d want 0", gnt);
    end
    step();
  endtask

  task automatic test_err_write();
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 4'b0011;
    d_dat = 32'hDEAD_BEEF; d_adr = ADR_W'(32'h40);
    step();
    look();
    checks++;
    if (s_we !== 1'b1 || s_sel !== 4'b0011 || s_dato !== 32'hDEAD_BEEF || s_adr !== ADR_W'(32'h40)) begin
      errors++; $display("FAIL err_wr_fields: we %b sel %b dat %h adr %h want 1 0011 deadbeef 40",
                         s_we, s_sel, s_dato, s_adr);
    end
    step();
    d_stb = 1'b0; s_err = 1'b1; i_cyc = 1'b1; i_stb = 1'b0; i_adr = ADR_W'(32'h77);
    look();
    checks++;
    if (d_err !== 1'b1 || d_ack !== 1'b0 || i_err !== 1'b0) begin
      errors++; $display("FAIL err_resp: derr %b dack %b ierr %b want 1 0 0", d_err, d_ack, i_err);
    end
    step();
    s_err = 1'b0; d_cyc = 1'b0;
    step();
    i_stb = 1'b1;
    look();
    checks++;
    if (gnt !== GNT_I || s_we !== 1'b0 || s_sel !== 4'hF || s_adr !== ADR_W'(32'h77) || s_stb !== 1'b1) begin
      errors++; $display("FAIL err_fetch_fields: gnt %0d we %b sel %h adr %h stb %b want 1 0 f 77 1",
                         gnt, s_we, s_sel, s_adr, s_stb);
    end
    step();
    i_stb = 1'b0; s_ack = 1'b1;
    look();
    checks++;
    if (i_ack !== 1'b1) begin
      errors++; $display("FAIL err_fetch_ack: got %b want 1", i_ack);
    end
    step();
    s_ack = 1'b0; i_cyc = 1'b0; d_we = 1'b0;
    step();
    step();
  endtask

  task automatic test_round_robin();
    gnt_e want;
    r_i_cyc = 1'b1;
    step();
    look();
    checks++;
    if (r_gnt !== GNT_I) begin
      errors++; $display("FAIL rr_prime: gnt %0d want 1", r_gnt);
    end
    r_i_cyc = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? GNT_D : GNT_I;
      r_i_cyc = 1'b1; r_d_cyc = 1'b1;
      step();
      look();
      checks++;
      if (r_gnt !== want) begin
        errors++; $display("FAIL rr_tie%0d: gnt %0d want %0d", k, r_gnt, want);
      end
      r_i_cyc = 1'b0; r_d_cyc = 1'b0;
      step();
    end
    step();
  endtask

  task automatic test_reset_mid();
    d_cyc = 1'b1; d_stb = 1'b1; d_sel = 4'hF; s_stall = 1'b0;
    step();
    step();
    step();
    s_stall = 1'b1; rst = 1'b1;
    look();
    checks++;
    if (d_stall !== 1'b1) begin
      errors++; $display("FAIL rstmid_full: stall %b want 1", d_stall);
    end
    step();
    rst = 1'b0;
    look();
    checks++;
    if (s_cyc !== 1'b0 || gnt !== GNT_NONE || d_stall !== 1'b1) begin
      errors++; $display("FAIL rstmid_after: cyc %b gnt %0d stall %b want 0 0 1", s_cyc, gnt, d_stall);
    end
    s_stall = 1'b0;
    step();
    look();
    checks++;
    if (gnt !== GNT_D || d_stall !== 1'b0 || s_stb !== 1'b1) begin
      errors++; $display("FAIL rstmid_regrant: gnt %0d stall %b stb %b want 2 0 1", gnt, d_stall, s_stb);
    end
    step();
    look();
    checks++;
    if (d_stall !== 1'b0) begin
      errors++; $display("FAIL rstmid_cnt_cleared: stall %b want 0", d_stall);
    end
    step();
    look();
    checks++;
    if (d_stall !== 1'b1) begin
      errors++; $display("FAIL rstmid_refill: stall %b want 1", d_stall);
    end
    d_stb = 1'b0; s_ack = 1'b1;
    step();
    step();
    s_ack = 1'b0; d_cyc = 1'b0;
    step();
    step();
  endtask

  // Transaction model: each master runs bursts; the slave answers requests in order
  // after a random delay; the queue length is the number of requests in flight.
  task automatic test_random();
    int   left[2];
    int   pend[2];
    bit   act[2];
    int   rdy_q[$];
    gnt_e exp_gnt;
    int   cyc_n;
    int   gi;
    bit   resp, is_i, is_d, full, acc, own_cyc, oth_cyc;
    logic e_scyc, e_sstb, e_istall, e_dstall, e_we;
    logic [SEL_W-1:0] e_sel;
    logic [ADR_W-1:0] e_adr;
    exp_gnt = GNT_NONE;
    cyc_n = 0;
    for (int m = 0; m < 2; m++) begin
      left[m] = 0; pend[m] = 0; act[m] = 1'b0;
    end
    for (int n = 0; n < 700; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (act[m] && left[m] == 0 && pend[m] == 0) begin
          act[m] = 1'b0;
        end else if (!act[m] && n < 600 && $urandom_range(0, 3) == 0) begin
          act[m] = 1'b1;
          left[m] = $urandom_range(1, 4);
        end
      end
      i_cyc = act[0]; i_stb = act[0] && left[0] > 0;
      d_cyc = act[1]; d_stb = act[1] && left[1] > 0;
      i_adr = ADR_W'($urandom); d_adr = ADR_W'($urandom);
      d_dat = $urandom; d_we = 1'($urandom); d_sel = SEL_W'($urandom);
      s_stall = ($urandom_range(0, 3) == 0);
      s_dat = $urandom;
      resp = (rdy_q.size() > 0) && (rdy_q[0] <= cyc_n);
      s_err = resp && ($urandom_range(0, 7) == 0);
      s_ack = resp && !s_err;

      is_i = (exp_gnt == GNT_I);
      is_d = (exp_gnt == GNT_D);
      full = (rdy_q.size() == MAXO);
      e_scyc   = is_i ? i_cyc : (is_d ? d_cyc : 1'b0);
      e_sstb   = e_scyc && (is_i ? i_stb : d_stb) && !full;
      e_istall = is_i ? (s_stall || full) : 1'b1;
      e_dstall = is_d ? (s_stall || full) : 1'b1;
      e_we     = is_d && d_we;
      e_sel    = is_d ? d_sel : '1;
      e_adr    = is_d ? d_adr : i_adr;

      look();
      checks++;
      if (gnt !== exp_gnt) begin
        errors++; $display("FAIL rnd_gnt n%0d: got %0d want %0d", n, gnt, exp_gnt);
      end
      checks++;
      if ({s_cyc, s_stb, i_stall, d_stall} !== {e_scyc, e_sstb, e_istall, e_dstall}) begin
        errors++; $display("FAIL rnd_ctl n%0d: got %b want %b", n,
                           {s_cyc, s_stb, i_stall, d_stall}, {e_scyc, e_sstb, e_istall, e_dstall});
      end
      checks++;
      if ({i_ack, i_err, d_ack, d_err} !== {is_i && s_ack, is_i && s_err, is_d && s_ack, is_d && s_err}) begin
        errors++; $display("FAIL rnd_resp n%0d: got %b want %b", n, {i_ack, i_err, d_ack, d_err},
                           {is_i && s_ack, is_i && s_err, is_d && s_ack, is_d && s_err});
      end
      checks++;
      if (s_we !== e_we || s_sel !== e_sel || s_adr !== e_adr) begin
        errors++; $display("FAIL rnd_req n%0d: we %b sel %h adr %h want %b %h %h", n,
                           s_we, s_sel, s_adr, e_we, e_sel, e_adr);
      end
      if (is_d) begin
        checks++;
        if (s_dato !== d_dat) begin
          errors++; $display("FAIL rnd_wdat n%0d: got %h want %h", n, s_dato, d_dat);
        end
      end
      checks++;
      if (i_dato !== s_dat || d_dato !== s_dat) begin
        errors++; $display("FAIL rnd_rdat n%0d: got %h/%h want %h", n, i_dato, d_dato, s_dat);
      end

      gi = is_d ? 1 : 0;
      acc = e_sstb && !s_stall;
      if (resp) begin
        void'(rdy_q.pop_front());
        pend[gi]--;
      end
      if (acc) begin
        rdy_q.push_back(cyc_n + int'($urandom_range(1, 5)));
        pend[gi]++;
        left[gi]--;
      end
      own_cyc = is_i ? i_cyc : d_cyc;
      oth_cyc = is_i ? d_cyc : i_cyc;
      if (exp_gnt == GNT_NONE) begin
        exp_gnt = d_cyc ? GNT_D : (i_cyc ? GNT_I : GNT_NONE);
      end else if (!own_cyc) begin
        exp_gnt = oth_cyc ? (is_i ? GNT_D : GNT_I) : GNT_NONE;
      end
      cyc_n++;
      step();
    end
    idle_inputs();
    look();
    checks++;
    if (exp_gnt != GNT_NONE || gnt !== GNT_NONE || rdy_q.size() != 0) begin
      errors++; $display("FAIL rnd_drain: gnt %0d model %0d inflight %0d want 0 0 0",
                         gnt, exp_gnt, rdy_q.size());
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t want completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_tie_fixed();
    test_max_out();
    test_err_write();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
